// File: rtl/trig_multi.sv
// Multi-source trigger unit: selects one asynchronous source, synchronizes it,
// detects edges and runs the IDLE/ARMED/TRIG/HOLDOFF trigger state machine.
module trig_multi #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         trig_in,
    input  logic [$clog2(NUM_SRC)-1:0] trig_src,
    input  logic [1:0]                 trig_mode,
    input  logic                       trig_en,
    input  logic                       armed,
    input  logic                       set_capture_done,
    input  logic [HOLDOFF_W-1:0]       holdoff,
    output logic                       triggered,
    output logic                       trig_pulse,
    output logic [1:0]                 trig_state,
    output logic [CNT_W-1:0]           trig_cnt
);

    localparam int SRC_W    = $clog2(NUM_SRC);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIG    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic                    src_sel;
    logic [SYNC_STAGES-1:0]  sync_p0;
    logic                    prev_p1;
    logic                    cur;
    logic [SRC_W-1:0]        src_q;
    logic                    src_chg;
    logic [SETTLE_W-1:0]     settle_cnt;
    logic                    suppress;
    logic                    edge_rise, edge_fall, edge_hit;
    logic [HOLDOFF_W-1:0]    hold_cnt;
    logic                    fire;
    logic                    pulse_q;
    logic [CNT_W-1:0]        cnt_q;

    // Source mux: out-of-range selects read as a quiet (low) source
    always_comb begin
        src_sel = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (trig_src == SRC_W'(i)) src_sel = trig_in[i];
        end
    end

    // Stage p0: synchronizer chain, stage p1: history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], src_sel};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign cur       = sync_p0[SYNC_STAGES-1];
    assign edge_rise = cur & ~prev_p1;
    assign edge_fall = ~cur & prev_p1;

    // Blanking: the chain holds stale data after reset or a source switch, so
    // events stay masked until the new source has fully reached the history flop.
    assign src_chg  = (trig_src != src_q);
    assign suppress = src_chg | (settle_cnt != SETTLE_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            settle_cnt <= '0;
        end else begin
            src_q <= trig_src;
            if (src_chg)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_DONE)
                settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

    always_comb begin
        edge_hit = 1'b0;
        case (trig_mode)
            2'b00:   edge_hit = edge_rise;
            2'b01:   edge_hit = edge_fall;
            2'b10:   edge_hit = edge_rise | edge_fall;
            default: edge_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (armed && trig_en) state_nxt = ARMED;
            end
            ARMED: begin
                if (!armed || !trig_en)
                    state_nxt = IDLE;
                else if (!set_capture_done &&
                         (trig_mode == 2'b11 || (edge_hit && !suppress)))
                    state_nxt = TRIG;
            end
            TRIG: begin
                if (set_capture_done)
                    state_nxt = (holdoff == '0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holdoff length is latched on entry so later holdoff changes do not matter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == TRIG && state_nxt == HOLDOFF) begin
            hold_cnt <= holdoff - HOLDOFF_W'(1);
        end else if (state == HOLDOFF && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLDOFF_W'(1);
        end
    end

    assign fire = (state == ARMED) && (state_nxt == TRIG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= fire;
            if (fire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign triggered  = (state == TRIG);
    assign trig_pulse = pulse_q;
    assign trig_state = state;
    assign trig_cnt   = cnt_q;

endmodule

// File: tb/tb_trig_multi.sv
// Bench for trig_multi: directed scenarios plus randomized traffic, all checked
// every cycle against a cycle-level behavioural model of the trigger rules.
module tb_trig_multi;

    localparam int NSRC = 4;
    localparam int S    = 2;
    localparam int HW   = 16;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NSRC-1:0] trig_in = '0;
    logic [1:0]    trig_src = 2'd0;
    logic [1:0]    trig_mode = 2'd0;
    logic          trig_en = 1'b0;
    logic          armed = 1'b0;
    logic          scd = 1'b0;
    logic [HW-1:0] holdoff = '0;
    logic          triggered;
    logic          trig_pulse;
    logic [1:0]    trig_state;
    logic [CW-1:0] trig_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    trig_multi #(.NUM_SRC(NSRC), .SYNC_STAGES(S), .HOLDOFF_W(HW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .trig_in          (trig_in),
        .trig_src         (trig_src),
        .trig_mode        (trig_mode),
        .trig_en          (trig_en),
        .armed            (armed),
        .set_capture_done (scd),
        .holdoff          (holdoff),
        .triggered        (triggered),
        .trig_pulse       (trig_pulse),
        .trig_state       (trig_state),
        .trig_cnt         (trig_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: samp[n] is the selected source level seen in cycle n
    // (cycles counted from reset release); the detector sees it S cycles later.
    int m_state = 0;
    int m_cnt   = 0;
    int m_pulse = 0;
    int m_left  = 0;
    int cyc     = 0;
    int last_chg = -100;
    int prev_src = 0;
    bit samp[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pulse = 0; m_left = 0;
            cyc = 0; last_chg = -100; prev_src = 0;
            samp.delete();
        end else begin
            bit cur, prv, ev, supp;
            int nxt;
            if (int'(trig_src) != prev_src) last_chg = cyc;
            supp = (cyc <= S) || (cyc - last_chg <= S + 1);
            cur  = (cyc - S >= 0)     ? samp[cyc - S]     : 1'b0;
            prv  = (cyc - S - 1 >= 0) ? samp[cyc - S - 1] : 1'b0;
            case (trig_mode)
                2'd0:    ev = cur && !prv;
                2'd1:    ev = !cur && prv;
                2'd2:    ev = cur != prv;
                default: ev = 1'b0;
            endcase
            nxt = m_state;
            case (m_state)
                0: if (armed && trig_en) nxt = 1;
                1: begin
                    if (!armed || !trig_en) nxt = 0;
                    else if (!scd && (trig_mode == 2'd3 || (ev && !supp))) nxt = 2;
                end
                2: if (scd) begin
                    if (holdoff == 0) nxt = 0;
                    else begin nxt = 3; m_left = int'(holdoff); end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) nxt = 0;
                end
            endcase
            m_pulse = (m_state == 1 && nxt == 2) ? 1 : 0;
            if (m_pulse == 1) m_cnt = (m_cnt + 1) % (1 << CW);
            m_state = nxt;
            samp.push_back(trig_in[trig_src]);
            prev_src = int'(trig_src);
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("cmp_state",     int'(trig_state), m_state);
        check("cmp_triggered", int'(triggered),  (m_state == 2) ? 1 : 0);
        check("cmp_pulse",     int'(trig_pulse), m_pulse);
        check("cmp_cnt",       int'(trig_cnt),   m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input int tgt, input string name);
        for (int i = 0; i < 12 && int'(trig_state) != tgt; i++) tick();
        check(name, int'(trig_state), tgt);
    endtask

    initial begin
        int hcnt;
        trig_src = 2'd2;
        ticks(3);
        rst = 1'b0;
        armed = 1'b1; trig_en = 1'b1;
        ticks(8);
        check("armed_after_reset", int'(trig_state), 1);

        // Rising edge on source 2
        trig_in = 4'b0100;
        ticks(2);
        check("rise_not_yet", int'(triggered), 0);
        tick();
        check("rise_triggered", int'(triggered), 1);
        check("rise_pulse", int'(trig_pulse), 1);
        check("rise_cnt", int'(trig_cnt), 1);
        scd = 1'b1; tick(); scd = 1'b0;
        check("release_idle", int'(trig_state), 0);

        // Falling mode ignores a rising edge, then fires on the fall
        armed = 1'b0; trig_in = 4'b0000;
        ticks(6);
        armed = 1'b1; trig_mode = 2'd1;
        ticks(3);
        trig_in = 4'b0100;
        ticks(5);
        check("fall_ignores_rise", int'(trig_state), 1);
        trig_in = 4'b0000;
        ticks(3);
        check("fall_trig", int'(trig_state), 2);
        scd = 1'b1; tick(); scd = 1'b0;

        // Either-edge mode
        trig_mode = 2'd2;
        ticks(3);
        trig_in = 4'b0100;
        ticks(3);
        check("either_trig", int'(trig_state), 2);

        // Holdoff of 5 cycles, with holdoff and input changes ignored meanwhile
        holdoff = 16'd5; armed = 1'b0; scd = 1'b1;
        tick();
        scd = 1'b0; holdoff = 16'd0; trig_in = 4'b0000;
        check("holdoff_entry", int'(trig_state), 3);
        hcnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(trig_state) == 3) hcnt++;
            else break;
        end
        check("holdoff_len", hcnt, 5);
        check("holdoff_exit", int'(trig_state), 0);

        // Source switch onto an already-high source must not trigger
        trig_mode = 2'd0; trig_in = 4'b0010; trig_src = 2'd0;
        ticks(6);
        armed = 1'b1;
        ticks(3);
        check("switch_armed", int'(trig_state), 1);
        trig_src = 2'd1;
        ticks(8);
        check("switch_no_trig", int'(trig_state), 1);
        trig_in = 4'b0000;
        ticks(4);
        trig_in = 4'b0010;
        ticks(3);
        check("src1_trig", int'(trig_state), 2);
        scd = 1'b1; tick(); scd = 1'b0;

        // Edge coinciding with set_capture_done is blocked
        trig_in = 4'b0000;
        ticks(5);
        trig_in = 4'b0010;
        ticks(2);
        scd = 1'b1; tick(); scd = 1'b0;
        check("scd_blocks", int'(trig_state), 1);
        tick();
        check("edge_consumed", int'(trig_state), 1);

        // Force mode, then reset in the middle of TRIG
        trig_mode = 2'd3;
        tick();
        check("force_trig", int'(trig_state), 2);
        rst = 1'b1;
        #1;
        check("rst_triggered", int'(triggered), 0);
        check("rst_cnt", int'(trig_cnt), 0);
        check("rst_state", int'(trig_state), 0);
        tick();
        rst = 1'b0;
        tick();
        check("force_armed", int'(trig_state), 1);
        tick();
        check("force_trig2", int'(trig_state), 2);
        check("force_pulse", int'(trig_pulse), 1);
        check("force_cnt", int'(trig_cnt), 1);

        // Counter wrap after 256 triggers
        scd = 1'b1; tick(); scd = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wait_state(2, "wrap_wait");
            if (i == 0) check("wrap_first", int'(trig_cnt), 1);
            if (i == 255) check("wrap_last", int'(trig_cnt), 0);
            scd = 1'b1; tick(); scd = 1'b0;
        end
        check("cnt_wrap", int'(trig_cnt), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) trig_in[$urandom_range(0, NSRC-1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) trig_src = 2'($urandom_range(0, NSRC-1));
            if ($urandom_range(0, 49) == 0) trig_mode = 2'($urandom_range(0, 3));
            armed   = ($urandom_range(0, 19) != 0);
            trig_en = ($urandom_range(0, 29) != 0);
            scd     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) holdoff = 16'($urandom_range(0, 6));
            tick();
        end
        rst = 1'b0;
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_multi.md
TRIG_MULTI -- requirements
Module: trig_multi

Interface
REQ-001 Parameter NUM_SRC, default 4: number of trigger sources, legal range 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-003 Parameter HOLDOFF_W, default 16: holdoff count width.
REQ-004 Parameter CNT_W, default 8: trigger event counter width.
REQ-005 Port clk, input, 1: the single clock; all flops on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port trig_in, input, NUM_SRC: asynchronous trigger sources; bit i is source i.
REQ-008 Port trig_src, input, $clog2(NUM_SRC): source select.
REQ-009 Port trig_mode, input, 2: 00 rising, 01 falling, 10 either edge, 11 force.
REQ-010 Port trig_en, input, 1: trigger enable.
REQ-011 Port armed, input, 1: capture engine armed.
REQ-012 Port set_capture_done, input, 1: capture complete; releases the trigger.
REQ-013 Port holdoff, input, HOLDOFF_W: holdoff length in cycles.
REQ-014 Port triggered, output, 1: high while state is TRIG.
REQ-015 Port trig_pulse, output, 1: one-cycle pulse on each entry to TRIG.
REQ-016 Port trig_state, output, 2: current FSM state.
REQ-017 Port trig_cnt, output, CNT_W: count of TRIG entries.

Function
REQ-018 trig_in[trig_src] SHALL be selected combinationally, then passed through SYNC_STAGES flops, then one history flop.
REQ-019 Edge detection SHALL compare the last sync stage (cur) with the history flop (prev):
- rise = cur & ~prev
- fall = ~cur & prev
- either = rise | fall
REQ-020 A source change sampled at edge k SHALL make the edge event visible during cycle k+SYNC_STAGES-1, with triggered high after edge k+SYNC_STAGES.
REQ-021 Register trig_src; when it differs from its registered value, edge events SHALL be suppressed for that cycle plus the next SYNC_STAGES+1 cycles.
REQ-022 FSM states SHALL be encoded IDLE=0, ARMED=1, TRIG=2, HOLDOFF=3.
REQ-023 IDLE -> ARMED when armed & trig_en.
REQ-024 ARMED -> IDLE when ~armed | ~trig_en; this check has the highest priority in ARMED.
REQ-025 ARMED -> TRIG on an unsuppressed edge event matching trig_mode, or unconditionally when trig_mode=11, provided set_capture_done=0.
REQ-026 set_capture_done=1 in ARMED SHALL block the trigger for that cycle; state stays ARMED.
REQ-027 TRIG SHALL hold, regardless of armed, trig_en and trig_mode, until set_capture_done=1.
REQ-028 TRIG on set_capture_done SHALL go to IDLE if holdoff=0; otherwise to HOLDOFF, loading counter=holdoff-1.
REQ-029 HOLDOFF SHALL decrement each cycle and go to IDLE in the cycle after the counter reads 0, giving exactly holdoff cycles in HOLDOFF.
REQ-030 Changes to holdoff during HOLDOFF SHALL be ignored; all inputs except rst SHALL be ignored in HOLDOFF.
REQ-031 set_capture_done in IDLE or HOLDOFF SHALL have no effect.
REQ-032 Outputs:
- triggered = (state==TRIG), registered.
- trig_pulse SHALL be high exactly the first cycle of TRIG.
- trig_cnt SHALL increment by one on each ARMED->TRIG and wrap modulo 2^CNT_W.

Reset
REQ-033 rst=1 SHALL immediately clear all flops, including sync chain, history, blanking counter and holdoff counter, and set state=IDLE.
REQ-034 During reset: triggered=0, trig_pulse=0, trig_state=0, trig_cnt=0.
REQ-035 Reset asserted in any state, including TRIG and HOLDOFF, SHALL abort to IDLE with no pulse on release.
REQ-036 After rst deasserts, the first edge-event evaluation SHALL occur no earlier than SYNC_STAGES+1 cycles later; a source already high at reset release SHALL not produce a rising event.

Verification
REQ-037 Rising edge, defaults: armed=1, trig_en=1, trig_mode=00, trig_src=2; raise trig_in[2] -> triggered=1 and trig_pulse=1 after edge k+2, trig_cnt=1; set_capture_done with holdoff=0 -> IDLE the next cycle.
REQ-038 Falling / either: trig_mode=01 with a rising then a falling input -> only the falling edge triggers; trig_mode=10 -> the first transition triggers.
REQ-039 Holdoff: holdoff=5, trigger, then set_capture_done -> trig_state=3 for exactly 5 cycles, then IDLE; input edges during holdoff produce no trigger.
REQ-040 Source switch: trig_in[0]=0, trig_in[1]=1, switch trig_src 0->1 while ARMED -> no trigger; a later clean edge on source 1 triggers.
REQ-041 Priority and reset: edge and set_capture_done in the same cycle -> stays ARMED; rst pulse mid-TRIG -> triggered=0 immediately and trig_cnt=0; force mode -> TRIG one cycle after ARMED.
REQ-042 Counter wrap: 256 triggers with CNT_W=8 -> trig_cnt returns to 0.
